decoder_nm_seq: RTL



---
 rtl/decoder_nm_seq_pkg.sv | 31 +++
 rtl/decoder_nm_seq_if.sv | 26 ++
 rtl/decoder_nm_seq_hold_timer.sv | 28 ++
 rtl/decoder_nm_seq.sv | 100 ++++++++++
 4 files changed

// File: rtl/decoder_nm_seq_pkg.sv
// Shared types and helpers for the registered N-to-2^N decoder family.
// Helpers return 64-bit vectors (widest legal output); callers slice to their own width.
package decoder_pkg;

  localparam int CNT_W     = 16;
  localparam int MAX_OUT_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [MAX_OUT_W-1:0] onehot(input int code, input int width);
    logic [MAX_OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_OUT_W; i++) begin
      r[i] = (i == code) && (i < width);
    end
    return r;
  endfunction

  function automatic logic [MAX_OUT_W-1:0] idle_val(input bit act_low, input int width);
    logic [MAX_OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_OUT_W; i++) begin
      r[i] = act_low && (i < width);
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_nm_seq_if.sv
// Handshake and result bundle between the decoder and its control logic.
interface decoder_nm_seq_if
  import decoder_pkg::*;
#(
  parameter int IN_W = 3
) ();
  localparam int OUT_W = 2 ** IN_W;

  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic [CNT_W-1:0] decode_cnt;

  modport master (
    output en, in_valid, in_code,
    input  in_ready, out, out_valid, decode_cnt
  );

  modport slave (
    input  en, in_valid, in_code,
    output in_ready, out, out_valid, decode_cnt
  );
endinterface

// File: rtl/decoder_nm_seq_hold_timer.sv
// Loadable down-counter that measures how long a decoded strobe stays asserted.
// Load wins over counting; the count parks at zero and raises o_zero there.
module hold_timer #(
  parameter int W = 3
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/decoder_nm_seq.sv
// Registered one-hot/one-cold decoder with valid/ready input, fixed strobe hold
// time and a saturating count of accepted codes.
module decoder_nm_seq
  import decoder_pkg::*;
#(
  parameter int IN_W     = 3,
  parameter int HOLD_CYC = 4,
  parameter int ACT_LOW  = 0
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  decoder_nm_seq_if.slave bus
);

  localparam int OUT_W = 2 ** IN_W;
  localparam int HC_W  = $clog2(HOLD_CYC + 1);

  localparam logic [MAX_OUT_W-1:0] IDLE_FULL = idle_val(ACT_LOW != 0, OUT_W);
  localparam logic [OUT_W-1:0]     IDLE_VAL  = IDLE_FULL[OUT_W-1:0];
  localparam logic [HC_W-1:0]      HOLD_LOAD = HC_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;

  state_e           r_state, w_state_nxt;
  logic [OUT_W-1:0] r_out, w_out_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_hzero;
  logic [MAX_OUT_W-1:0] w_onehot_full;
  logic [OUT_W-1:0]     w_decoded;

  hold_timer #(.W(HC_W)) u_hold_timer (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .i_load     (w_accept),
    .i_load_val (HOLD_LOAD),
    .o_zero     (w_hzero)
  );

  // XOR with the idle pattern turns the one-hot into one-cold when ACT_LOW is set.
  always_comb begin
    w_onehot_full = onehot(32'(bus.in_code), OUT_W);
    w_decoded     = w_onehot_full[OUT_W-1:0] ^ IDLE_VAL;
    w_ready       = bus.en & ((r_state == IDLE) | ((r_state == HOLD) & w_hzero));
    w_accept      = bus.in_valid & w_ready;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_out_nxt       = r_out;
    w_out_valid_nxt = r_out_valid;
    w_cnt_nxt       = r_cnt;

    if (w_accept) begin
      w_state_nxt     = HOLD;
      w_out_nxt       = w_decoded;
      w_out_valid_nxt = 1'b1;
      if (r_cnt != CNT_MAX) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end else begin
      case (r_state)
        HOLD: begin
          if (w_hzero) begin
            w_state_nxt     = IDLE;
            w_out_nxt       = IDLE_VAL;
            w_out_valid_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // NOTE: reset is synchronous and dominates an in-progress hold and any same-edge accept.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= IDLE;
      r_out       <= IDLE_VAL;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.out        = r_out;
  assign bus.out_valid  = r_out_valid;
  assign bus.decode_cnt = r_cnt;

endmodule
